// File: rtl/amt_recovery_pkg.sv
// Shared constants and FSM state type for the AMT -> RMT recovery sequencer.
package amt_recovery_pkg;

    localparam int SIZE_RMT          = 32;
    localparam int SIZE_RMT_LOG      = 5;
    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int PACKET_W          = SIZE_RMT_LOG + SIZE_PHYSICAL_LOG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } rec_state_e;

endpackage

// File: rtl/amt_recovery_ctrl.sv
// Walks the Architectural Map Table four entries per cycle after a recovery
// request and rewrites the Rename Map Table from it, stalling rename meanwhile.
module amt_recovery_ctrl #(
    parameter int SIZE_RMT          = amt_recovery_pkg::SIZE_RMT,
    parameter int SIZE_RMT_LOG      = amt_recovery_pkg::SIZE_RMT_LOG,
    parameter int SIZE_PHYSICAL_LOG = amt_recovery_pkg::SIZE_PHYSICAL_LOG
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      recoverReq_i,
    input  logic [SIZE_RMT_LOG-1:0]                   commitAddr0_i,
    input  logic [SIZE_RMT_LOG-1:0]                   commitAddr1_i,
    input  logic [SIZE_RMT_LOG-1:0]                   commitAddr2_i,
    input  logic [SIZE_RMT_LOG-1:0]                   commitAddr3_i,
    output logic [SIZE_RMT_LOG-1:0]                   amtAddr0_o,
    output logic [SIZE_RMT_LOG-1:0]                   amtAddr1_o,
    output logic [SIZE_RMT_LOG-1:0]                   amtAddr2_o,
    output logic [SIZE_RMT_LOG-1:0]                   amtAddr3_o,
    input  logic [SIZE_PHYSICAL_LOG-1:0]              amtData0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]              amtData1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]              amtData2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]              amtData3_i,
    output logic [3:0]                                rmtWe_o,
    output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket0_o,
    output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket1_o,
    output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket2_o,
    output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket3_o,
    output logic                                      recoverBusy_o,
    output logic                                      recoverDone_o
);

    import amt_recovery_pkg::*;

    localparam logic [SIZE_RMT_LOG-1:0] LAST_GROUP = SIZE_RMT_LOG'(SIZE_RMT - 4);
    localparam logic [SIZE_RMT_LOG-1:0] GROUP_STEP = SIZE_RMT_LOG'(4);

    rec_state_e              state_q, state_d;
    logic [SIZE_RMT_LOG-1:0] walk_cnt_q, walk_cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [SIZE_RMT_LOG-1:0] lane_addr0, lane_addr1, lane_addr2, lane_addr3;
    logic                    in_walk;

    // Requests arriving outside IDLE are dropped: the Active List has already flushed.
    always_comb begin
        state_d    = state_q;
        walk_cnt_d = walk_cnt_q;
        case (state_q)
            IDLE: begin
                if (recoverReq_i) begin
                    state_d    = WALK;
                    walk_cnt_d = '0;
                end
            end
            WALK: begin
                if (walk_cnt_q == LAST_GROUP) begin
                    state_d    = DONE;
                    walk_cnt_d = '0;
                end else begin
                    walk_cnt_d = walk_cnt_q + GROUP_STEP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WALK);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            walk_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            walk_cnt_q <= walk_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // AMT reads are asynchronous, so each lane's packet is formed in the same cycle.
    always_comb begin
        in_walk    = (state_q == WALK);
        lane_addr0 = walk_cnt_q;
        lane_addr1 = walk_cnt_q + SIZE_RMT_LOG'(1);
        lane_addr2 = walk_cnt_q + SIZE_RMT_LOG'(2);
        lane_addr3 = walk_cnt_q + SIZE_RMT_LOG'(3);

        amtAddr0_o   = commitAddr0_i;
        amtAddr1_o   = commitAddr1_i;
        amtAddr2_o   = commitAddr2_i;
        amtAddr3_o   = commitAddr3_i;
        rmtWe_o      = 4'b0000;
        rmtPacket0_o = '0;
        rmtPacket1_o = '0;
        rmtPacket2_o = '0;
        rmtPacket3_o = '0;

        if (in_walk) begin
            amtAddr0_o   = lane_addr0;
            amtAddr1_o   = lane_addr1;
            amtAddr2_o   = lane_addr2;
            amtAddr3_o   = lane_addr3;
            rmtWe_o      = 4'b1111;
            rmtPacket0_o = {lane_addr0, amtData0_i};
            rmtPacket1_o = {lane_addr1, amtData1_i};
            rmtPacket2_o = {lane_addr2, amtData2_i};
            rmtPacket3_o = {lane_addr3, amtData3_i};
        end
    end

    assign recoverBusy_o = busy_q;
    assign recoverDone_o = done_q;

endmodule

// File: tb/tb_amt_recovery_ctrl.sv
// Self-checking bench for amt_recovery_ctrl: a behavioural AMT/RMT model checks
// walk order, packets, timing, request collisions, reset abort and a 64-entry build.
module tb_amt_recovery_ctrl;

    logic clk;
    logic reset;

    // default-size instance signals
    logic        req;
    logic [4:0]  commit_addr [4];
    logic [4:0]  amt_addr    [4];
    logic [6:0]  amt_data    [4];
    logic [3:0]  rmt_we;
    logic [11:0] pkt         [4];
    logic        busy;
    logic        done;

    // 64-entry instance signals
    logic        b_req;
    logic [5:0]  b_commit_addr [4];
    logic [5:0]  b_amt_addr    [4];
    logic [6:0]  b_amt_data    [4];
    logic [3:0]  b_rmt_we;
    logic [12:0] b_pkt         [4];
    logic        b_busy;
    logic        b_done;

    // behavioural AMT (driven only by the stimulus process) and RMT images
    logic [6:0] amt [32];
    logic [6:0] rmt [32];
    logic       rmt_clr;

    int vectors;
    int miscompares;

    amt_recovery_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .recoverReq_i  (req),
        .commitAddr0_i (commit_addr[0]),
        .commitAddr1_i (commit_addr[1]),
        .commitAddr2_i (commit_addr[2]),
        .commitAddr3_i (commit_addr[3]),
        .amtAddr0_o    (amt_addr[0]),
        .amtAddr1_o    (amt_addr[1]),
        .amtAddr2_o    (amt_addr[2]),
        .amtAddr3_o    (amt_addr[3]),
        .amtData0_i    (amt_data[0]),
        .amtData1_i    (amt_data[1]),
        .amtData2_i    (amt_data[2]),
        .amtData3_i    (amt_data[3]),
        .rmtWe_o       (rmt_we),
        .rmtPacket0_o  (pkt[0]),
        .rmtPacket1_o  (pkt[1]),
        .rmtPacket2_o  (pkt[2]),
        .rmtPacket3_o  (pkt[3]),
        .recoverBusy_o (busy),
        .recoverDone_o (done)
    );

    amt_recovery_ctrl #(
        .SIZE_RMT          (64),
        .SIZE_RMT_LOG      (6),
        .SIZE_PHYSICAL_LOG (7)
    ) dut64 (
        .clk           (clk),
        .reset         (reset),
        .recoverReq_i  (b_req),
        .commitAddr0_i (b_commit_addr[0]),
        .commitAddr1_i (b_commit_addr[1]),
        .commitAddr2_i (b_commit_addr[2]),
        .commitAddr3_i (b_commit_addr[3]),
        .amtAddr0_o    (b_amt_addr[0]),
        .amtAddr1_o    (b_amt_addr[1]),
        .amtAddr2_o    (b_amt_addr[2]),
        .amtAddr3_o    (b_amt_addr[3]),
        .amtData0_i    (b_amt_data[0]),
        .amtData1_i    (b_amt_data[1]),
        .amtData2_i    (b_amt_data[2]),
        .amtData3_i    (b_amt_data[3]),
        .rmtWe_o       (b_rmt_we),
        .rmtPacket0_o  (b_pkt[0]),
        .rmtPacket1_o  (b_pkt[1]),
        .rmtPacket2_o  (b_pkt[2]),
        .rmtPacket3_o  (b_pkt[3]),
        .recoverBusy_o (b_busy),
        .recoverDone_o (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // asynchronous AMT read ports
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            amt_data[n]   = amt[amt_addr[n]];
            b_amt_data[n] = {1'b0, b_amt_addr[n]} ^ 7'h2A;
        end
    end

    // RMT image captures whatever the DUT writes
    always @(posedge clk) begin
        if (rmt_clr) begin
            for (int i = 0; i < 32; i++) rmt[i] <= '0;
        end else begin
            for (int n = 0; n < 4; n++)
                if (rmt_we[n]) rmt[pkt[n][11:7]] <= pkt[n][6:0];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_commits();
        for (int n = 0; n < 4; n++) begin
            commit_addr[n]   = 5'($urandom_range(0, 31));
            b_commit_addr[n] = 6'($urandom_range(0, 63));
        end
    endtask

    task automatic clear_rmt();
        rmt_clr = 1'b1;
        step();
        rmt_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 1'b0;
        b_req = 1'b0;
        randomize_commits();
        step();
        step();
        reset = 1'b0;
        commit_addr[0] = 5'd5;
        @(negedge clk);
        vectors++;
        if (amt_addr[0] !== 5'd5) begin
            miscompares++;
            $display("[TB] FAIL reset_addr0: got %0d want 5", amt_addr[0]);
        end
        vectors++;
        if (rmt_we !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: we=%b busy=%b done=%b want 0/0/0", rmt_we, busy, done);
        end
        for (int n = 0; n < 4; n++) begin
            vectors++;
            if (pkt[n] !== 12'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_pkt%0d: got %h want 0", n, pkt[n]);
            end
        end
        step();
    endtask

    task automatic test_idle_passthrough();
        for (int it = 0; it < 4; it++) begin
            randomize_commits();
            @(negedge clk);
            for (int n = 0; n < 4; n++) begin
                vectors++;
                if (amt_addr[n] !== commit_addr[n] || b_amt_addr[n] !== b_commit_addr[n]) begin
                    miscompares++;
                    $display("[TB] FAIL idle_addr%0d: got %0d/%0d want %0d/%0d", n,
                             amt_addr[n], b_amt_addr[n], commit_addr[n], b_commit_addr[n]);
                end
            end
            vectors++;
            if (rmt_we !== 4'b0000 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_ctrl: we=%b busy=%b want 0/0", rmt_we, busy);
            end
            step();
        end
    endtask

    // Full walk; iteration 0 uses AMT[i]=i+32, later ones random AMT contents.
    task automatic test_walk(input int iterations);
        logic [4:0]  exp_addr;
        logic [11:0] exp_pkt;
        for (int it = 0; it < iterations; it++) begin
            for (int i = 0; i < 32; i++)
                amt[i] = (it == 0) ? 7'(i + 32) : 7'($urandom_range(0, 127));
            clear_rmt();
            req = 1'b1;
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL walk_T_busy: got %b want 0", busy);
            end
            step();
            req = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                randomize_commits();
                @(negedge clk);
                vectors++;
                if (busy !== 1'b1 || done !== 1'b0 || rmt_we !== 4'b1111) begin
                    miscompares++;
                    $display("[TB] FAIL walk_ctrl T+%0d: busy=%b done=%b we=%b want 1/0/1111",
                             k, busy, done, rmt_we);
                end
                for (int n = 0; n < 4; n++) begin
                    exp_addr = 5'(4 * (k - 1) + n);
                    exp_pkt  = {exp_addr, amt[exp_addr]};
                    vectors++;
                    if (pkt[n] !== exp_pkt || amt_addr[n] !== exp_addr) begin
                        miscompares++;
                        $display("[TB] FAIL walk_pkt T+%0d port%0d: pkt=%h addr=%0d want pkt=%h addr=%0d",
                                 k, n, pkt[n], amt_addr[n], exp_pkt, exp_addr);
                    end
                end
                step();
            end
            randomize_commits();
            @(negedge clk);
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0 || rmt_we !== 4'b0000 || amt_addr[2] !== commit_addr[2]) begin
                miscompares++;
                $display("[TB] FAIL walk_done T+9: done=%b busy=%b we=%b addr2=%0d want 1/0/0000/%0d",
                         done, busy, rmt_we, amt_addr[2], commit_addr[2]);
            end
            step();
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL walk_done_pulse T+10: got %b want 0", done);
            end
            for (int i = 0; i < 32; i++) begin
                vectors++;
                if (rmt[i] !== amt[i]) begin
                    miscompares++;
                    $display("[TB] FAIL rmt_restore[%0d]: got %0d want %0d", i, rmt[i], amt[i]);
                end
            end
            step();
        end
    endtask

    // Commit to AMT[7] lands at the same edge that accepts the request.
    task automatic test_commit_collision();
        int done_cycle;
        for (int i = 0; i < 32; i++) amt[i] = 7'($urandom_range(0, 127));
        amt[7] = 7'd0;
        req = 1'b1;
        @(posedge clk);
        amt[7] = 7'd99;
        #1;
        req = 1'b0;
        step();
        @(negedge clk);
        vectors++;
        if (pkt[3] !== {5'd7, 7'd99}) begin
            miscompares++;
            $display("[TB] FAIL commit_collision T+2 port3: got %h want %h", pkt[3], {5'd7, 7'd99});
        end
        done_cycle = 0;
        for (int c = 3; c <= 12; c++) begin
            step();
            @(negedge clk);
            if (done === 1'b1 && done_cycle == 0) done_cycle = c;
        end
        vectors++;
        if (done_cycle != 9) begin
            miscompares++;
            $display("[TB] FAIL commit_collision_done: got cycle %0d want 9", done_cycle);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int we_cycles;
        int done_cycle;
        int busy_cycles;
        we_cycles   = 0;
        busy_cycles = 0;
        done_cycle  = 0;
        req = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            req = (c == 4 || c == 9) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (rmt_we === 4'b1111) we_cycles++;
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1 && done_cycle == 0) done_cycle = c;
            step();
        end
        req = 1'b0;
        vectors++;
        if (we_cycles != 8 || busy_cycles != 8) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_len: we=%0d busy=%0d want 8/8", we_cycles, busy_cycles);
        end
        vectors++;
        if (done_cycle != 9) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_done: got cycle %0d want 9", done_cycle);
        end
        for (int c = 0; c < 3; c++) step();
    endtask

    task automatic test_reset_midwalk();
        int done_cycle;
        for (int i = 0; i < 32; i++) amt[i] = 7'($urandom_range(0, 127));
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rmt_we !== 4'b0000 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midwalk_reset T+5: busy=%b we=%b done=%b want 0/0000/0", busy, rmt_we, done);
        end
        step();
        req = 1'b1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midwalk_reset T+6: done=%b busy=%b want 0/0", done, busy);
        end
        step();
        req = 1'b0;
        @(negedge clk);
        vectors++;
        if (amt_addr[0] !== 5'd0 || pkt[0] !== {5'd0, amt[0]} || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midwalk_restart: addr0=%0d pkt0=%h busy=%b want 0/%h/1",
                     amt_addr[0], pkt[0], busy, {5'd0, amt[0]});
        end
        done_cycle = 0;
        for (int c = 2; c <= 11; c++) begin
            step();
            @(negedge clk);
            if (done === 1'b1 && done_cycle == 0) done_cycle = c;
        end
        vectors++;
        if (done_cycle != 9) begin
            miscompares++;
            $display("[TB] FAIL midwalk_restart_done: got cycle %0d want 9", done_cycle);
        end
        step();
    endtask

    task automatic test_size64();
        logic [5:0]  exp_addr;
        logic [12:0] exp_pkt;
        b_req = 1'b1;
        step();
        b_req = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            vectors++;
            if (b_busy !== 1'b1 || b_rmt_we !== 4'b1111) begin
                miscompares++;
                $display("[TB] FAIL size64_ctrl T+%0d: busy=%b we=%b want 1/1111", k, b_busy, b_rmt_we);
            end
            for (int n = 0; n < 4; n++) begin
                exp_addr = 6'(4 * (k - 1) + n);
                exp_pkt  = {exp_addr, {1'b0, exp_addr} ^ 7'h2A};
                vectors++;
                if (b_pkt[n] !== exp_pkt) begin
                    miscompares++;
                    $display("[TB] FAIL size64_pkt T+%0d port%0d: got %h want %h", k, n, b_pkt[n], exp_pkt);
                end
            end
            step();
        end
        @(negedge clk);
        vectors++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || b_amt_addr[1] !== b_commit_addr[1]) begin
            miscompares++;
            $display("[TB] FAIL size64_done T+17: done=%b busy=%b addr1=%0d want 1/0/%0d",
                     b_done, b_busy, b_amt_addr[1], b_commit_addr[1]);
        end
        step();
        step();
        b_req = 1'b1;
        step();
        b_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (b_amt_addr[0] !== 6'd0 || b_amt_addr[3] !== 6'd3) begin
            miscompares++;
            $display("[TB] FAIL size64_wrap: addr0=%0d addr3=%0d want 0/3", b_amt_addr[0], b_amt_addr[3]);
        end
        for (int c = 0; c < 20; c++) step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rmt_clr     = 1'b0;
        for (int i = 0; i < 32; i++) amt[i] = 7'(i);
        test_reset();
        test_idle_passthrough();
        test_walk(3);
        test_commit_collision();
        test_back_to_back();
        test_reset_midwalk();
        test_size64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/amt_recovery_ctrl.md
# amt_recovery_ctrl

Sequencer that restores the Rename Map Table from the Architectural Map Table after an exception or branch mis-prediction. On a recovery request from the Active List it walks every AMT entry four per cycle, steering the four AMT read ports to the walk counter and driving the four RMT write ports with the resulting mappings. While the walk runs it holds rename and commit off. The block sits between the Active List, the AMT read ports and the RMT write ports.

## Interface

Parameters:
- SIZE_RMT, 32, number of logical registers (AMT/RMT entries); multiple of 4, ≥ 8
- SIZE_RMT_LOG, 5, log2(SIZE_RMT)
- SIZE_PHYSICAL_LOG, 7, physical register tag width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- recoverReq_i  in  1  one-cycle pulse from Active List (exception or mis-predict)
- commitAddr0_i..commitAddr3_i  in  SIZE_RMT_LOG each  normal-mode AMT read addresses (committing logical destinations)
- amtAddr0_o..amtAddr3_o  out  SIZE_RMT_LOG each  AMT read addresses; mux of commit address vs. walk address
- amtData0_i..amtData3_i  in  SIZE_PHYSICAL_LOG each  AMT read data, combinational from amtAddrN_o
- rmtWe_o  out  4  per-port RMT write enables
- rmtPacket0_o..rmtPacket3_o  out  SIZE_RMT_LOG+SIZE_PHYSICAL_LOG each  {logical, physical} write packets
- recoverBusy_o  out  1  walk in progress; stalls rename and blocks AMT writes from commit
- recoverDone_o  out  1  one-cycle pulse after the last group is written

## Operation

- FSM states: IDLE, WALK, DONE.
- IDLE: amtAddrN_o = commitAddrN_i; rmtWe_o = 0. If recoverReq_i, go to WALK and clear walkCnt to 0.
- WALK:
  - amtAddrN_o = walkCnt + N, modulo SIZE_RMT_LOG bits.
  - rmtWe_o = 4'b1111.
  - rmtPacketN_o = {walkCnt+N, amtDataN_i}.
  - walkCnt += 4 each cycle.
  - When walkCnt == SIZE_RMT-4, go to DONE; walkCnt wraps to 0.
- DONE: rmtWe_o = 0; recoverDone_o = 1; amtAddrN_o follows the commit addresses. Next state is IDLE.
- recoverBusy_o = (state == WALK); it is a registered state decode.
- Walk length is exactly SIZE_RMT/4 cycles; no partial group exists.
- recoverReq_i during WALK or DONE is ignored. The Active List has already flushed, so a second request carries no new state.
- Commit and recoverReq_i in the same cycle: that commit's AMT write completes first, so the walk, which starts next cycle, reads post-commit AMT contents.
- Reset in any state:
  - next cycle state = IDLE, walkCnt = 0.
  - rmtWe_o = 0, recoverBusy_o = 0, recoverDone_o = 0.
  - A partially restored RMT is left as is.
- All arithmetic is unsigned, SIZE_RMT_LOG bits wide; walkCnt+N never exceeds SIZE_RMT-1 inside WALK.

## Timing

- Reset values: rmtWe_o = 0, rmtPacketN_o = 0, recoverBusy_o = 0, recoverDone_o = 0. amtAddrN_o passes commitAddrN_i through.
- recoverReq_i high at cycle T:
  - WALK occupies T+1 .. T+SIZE_RMT/4, which is T+1..T+8 at default.
  - DONE is at T+9; IDLE from T+10.
  - A new request is accepted at T+10 at the earliest.
- RMT writes occur at the clock edge ending each WALK cycle, so the RMT is fully restored at the edge ending T+8.
- rmtWe_o and rmtPacketN_o are combinational from state, walkCnt and amtDataN_i. AMT read is asynchronous, so there is no added read latency.
- Rename may resume in the cycle recoverDone_o is high.

## Structure

- Shared package holds:
  - the SIZE_RMT, SIZE_RMT_LOG and SIZE_PHYSICAL_LOG constants
  - the FSM state enum (IDLE/WALK/DONE)
  - the packet width constant SIZE_RMT_LOG+SIZE_PHYSICAL_LOG
- A single flat module; no sub-module. The address mux and packet build are four replicated lanes written inline.

## Test plan

- Reset, then idle: commitAddr0_i = 5 → amtAddr0_o = 5, rmtWe_o = 0, recoverBusy_o = 0.
- Preload AMT[i] = i+32, pulse recoverReq_i at T:
  - busy high T+1..T+8.
  - At T+1, packets {0,32},{1,33},{2,34},{3,35}.
  - At T+8, packets {28,60}..{31,63}.
  - recoverDone_o pulse at T+9.
  - RMT[i] == i+32 for all i.
- Commit writes AMT[7] = 99 in the same cycle as recoverReq_i → walk cycle T+2 drives {7,99} on port 3.
- Second recoverReq_i at T+4 → ignored; walk still ends with DONE at T+9; exactly 8 write cycles.
- Reset asserted at T+4 mid-walk → at T+5 busy = 0, rmtWe_o = 0, no done pulse. A fresh request at T+6 restarts from address 0.
- SIZE_RMT = 64: the walk lasts 16 cycles and walkCnt wraps to 0 after address 60.
